// File: rtl/agc_ctrl_pkg.sv
// Shared constants for the AGC control block: FSM state encodings,
// load-select codes and the default counter width.
package agc_ctrl_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    localparam logic LOAD_SEL_SCALE  = 1'b0;
    localparam logic LOAD_SEL_OFFSET = 1'b1;

    localparam int CNT_BITS_DEF = 24;

endpackage

// File: rtl/agc_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; used for the per-channel
// gt/lt saturation-flag statistics.
module agc_sat_counter
    import agc_ctrl_pkg::*;
#(
    parameter int CNT_BITS = CNT_BITS_DEF
) (
    input  logic                clk_i,
    input  logic                rstn_i,
    input  logic                clr_i,
    input  logic                inc_i,
    output logic [CNT_BITS-1:0] cnt_o
);

    logic [CNT_BITS-1:0] cnt_r;

    // Count register: clear wins over increment, and the count sticks at all-ones.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            cnt_r <= {CNT_BITS{1'b0}};
        end else if (clr_i) begin
            cnt_r <= {CNT_BITS{1'b0}};
        end else if (inc_i && (cnt_r != {CNT_BITS{1'b1}})) begin
            cnt_r <= cnt_r + {{(CNT_BITS-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign cnt_o = cnt_r;

endmodule

// File: rtl/agc_ctrl.sv
// AGC slice bank controller: staged scale/offset loads, measurement window
// with saturation counters, and window-aligned apply strobe.
// Optional: define AGC_CTRL_BCAST_EN to make load_chan_i == all-ones a broadcast load.
module agc_ctrl
    import agc_ctrl_pkg::*;
#(
    parameter int NCHAN       = 8,
    parameter int CHAN_BITS   = 3,
    parameter int OFFSET_BITS = 12,
    parameter int CNT_BITS    = CNT_BITS_DEF
) (
    input  logic                   clk_i,
    input  logic                   rstn_i,
    input  logic                   load_i,
    input  logic [CHAN_BITS-1:0]   load_chan_i,
    input  logic                   load_sel_i,
    input  logic [16:0]            load_dat_i,
    output logic [16:0]            scale_o,
    output logic [OFFSET_BITS-1:0] offset_o,
    output logic [NCHAN-1:0]       ce_scale_o,
    output logic [NCHAN-1:0]       ce_offset_o,
    input  logic                   apply_req_i,
    output logic                   apply_o,
    output logic                   apply_pend_o,
    input  logic [CNT_BITS-1:0]    window_len_i,
    input  logic                   start_i,
    input  logic [NCHAN-1:0]       gt_i,
    input  logic [NCHAN-1:0]       lt_i,
    output logic                   done_o,
    input  logic [CHAN_BITS-1:0]   rd_chan_i,
    output logic [CNT_BITS-1:0]    gt_cnt_o,
    output logic [CNT_BITS-1:0]    lt_cnt_o
);

    state_t                   state_r;
    logic [CNT_BITS-1:0]      timer_r;
    logic                     done_r;
    logic                     pend_r;
    logic                     apply_r;
    logic [16:0]              scale_r;
    logic [OFFSET_BITS-1:0]   offset_r;
    logic [NCHAN-1:0]         ce_scale_r;
    logic [NCHAN-1:0]         ce_offset_r;
    logic [CNT_BITS-1:0]      gt_q_r;
    logic [CNT_BITS-1:0]      lt_q_r;

    logic                     start_s;
    logic                     run_s;
    logic                     bcast_s;
    logic [CNT_BITS-1:0]      win_init_s;
    logic [NCHAN-1:0]         ce_hit_s;
    logic [NCHAN-1:0]         ce_sel_s;
    logic [CNT_BITS-1:0]      gt_sel_s;
    logic [CNT_BITS-1:0]      lt_sel_s;
    logic [CNT_BITS-1:0]      gt_cnt_s [NCHAN];
    logic [CNT_BITS-1:0]      lt_cnt_s [NCHAN];

    assign start_s    = start_i && (state_r != ST_RUN);
    assign run_s      = (state_r == ST_RUN);
    assign win_init_s = (window_len_i == {CNT_BITS{1'b0}}) ? {CNT_BITS{1'b0}}
                      : window_len_i - {{(CNT_BITS-1){1'b0}}, 1'b1};

`ifdef AGC_CTRL_BCAST_EN
    assign bcast_s = (load_chan_i == {CHAN_BITS{1'b1}});
`else
    assign bcast_s = 1'b0;
`endif

    // Channel decode for the load enables; out-of-range channels match nothing.
    always_comb begin
        ce_hit_s = {NCHAN{1'b0}};
        for (int c = 0; c < NCHAN; c++) begin
            ce_hit_s[c] = (load_chan_i == CHAN_BITS'(c));
        end
        ce_sel_s = bcast_s ? {NCHAN{1'b1}} : ce_hit_s;
    end

    // Readout mux; unmatched selects fall through to zero.
    always_comb begin
        gt_sel_s = {CNT_BITS{1'b0}};
        lt_sel_s = {CNT_BITS{1'b0}};
        for (int c = 0; c < NCHAN; c++) begin
            gt_sel_s = (rd_chan_i == CHAN_BITS'(c)) ? gt_cnt_s[c] : gt_sel_s;
            lt_sel_s = (rd_chan_i == CHAN_BITS'(c)) ? lt_cnt_s[c] : lt_sel_s;
        end
    end

    // Measurement FSM and window timer.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_r <= ST_IDLE;
            timer_r <= {CNT_BITS{1'b0}};
            done_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (start_i) begin
                        state_r <= ST_RUN;
                        timer_r <= win_init_s;
                        done_r  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (timer_r == {CNT_BITS{1'b0}}) begin
                        state_r <= ST_DONE;
                        done_r  <= 1'b1;
                    end else begin
                        timer_r <= timer_r - {{(CNT_BITS-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    timer_r <= {CNT_BITS{1'b0}};
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    // Apply handshake: the strobe is held back while a window is running.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            pend_r  <= 1'b0;
            apply_r <= 1'b0;
        end else begin
            apply_r <= pend_r && !run_s;
            pend_r  <= apply_req_i || (pend_r && run_s);
        end
    end

    // Load path: the buses keep their last value, enables pulse for one cycle.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            scale_r     <= 17'd0;
            offset_r    <= {OFFSET_BITS{1'b0}};
            ce_scale_r  <= {NCHAN{1'b0}};
            ce_offset_r <= {NCHAN{1'b0}};
        end else begin
            ce_scale_r  <= (load_i && (load_sel_i == LOAD_SEL_SCALE))  ? ce_sel_s : {NCHAN{1'b0}};
            ce_offset_r <= (load_i && (load_sel_i == LOAD_SEL_OFFSET)) ? ce_sel_s : {NCHAN{1'b0}};
            if (load_i && (load_sel_i == LOAD_SEL_SCALE)) begin
                scale_r <= load_dat_i;
            end
            if (load_i && (load_sel_i == LOAD_SEL_OFFSET)) begin
                offset_r <= load_dat_i[OFFSET_BITS-1:0];
            end
        end
    end

    // Registered counter readout.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            gt_q_r <= {CNT_BITS{1'b0}};
            lt_q_r <= {CNT_BITS{1'b0}};
        end else begin
            gt_q_r <= gt_sel_s;
            lt_q_r <= lt_sel_s;
        end
    end

    for (genvar c = 0; c < NCHAN; c++) begin : g_chan
        agc_sat_counter #(.CNT_BITS(CNT_BITS)) u_gt (
            .clk_i  (clk_i),
            .rstn_i (rstn_i),
            .clr_i  (start_s),
            .inc_i  (run_s && gt_i[c]),
            .cnt_o  (gt_cnt_s[c])
        );
        agc_sat_counter #(.CNT_BITS(CNT_BITS)) u_lt (
            .clk_i  (clk_i),
            .rstn_i (rstn_i),
            .clr_i  (start_s),
            .inc_i  (run_s && lt_i[c]),
            .cnt_o  (lt_cnt_s[c])
        );
    end

    assign scale_o      = scale_r;
    assign offset_o     = offset_r;
    assign ce_scale_o   = ce_scale_r;
    assign ce_offset_o  = ce_offset_r;
    assign apply_o      = apply_r;
    assign apply_pend_o = pend_r;
    assign done_o       = done_r;
    assign gt_cnt_o     = gt_q_r;
    assign lt_cnt_o     = lt_q_r;

endmodule

// File: tb/tb_agc_ctrl.sv
// Directed bench for agc_ctrl (NCHAN=8 with a 4-bit channel select so that
// out-of-range channels are reachable) plus a 4-bit saturating counter.
module tb_agc_ctrl;

    localparam int NCH = 8;
    localparam int CB  = 4;
    localparam int OB  = 12;
    localparam int CW  = 24;

    logic           clk = 1'b0;
    logic           rstn_i = 1'b0;
    logic           load_i = 1'b0;
    logic [CB-1:0]  load_chan_i = '0;
    logic           load_sel_i = 1'b0;
    logic [16:0]    load_dat_i = '0;
    logic [16:0]    scale_o;
    logic [OB-1:0]  offset_o;
    logic [NCH-1:0] ce_scale_o;
    logic [NCH-1:0] ce_offset_o;
    logic           apply_req_i = 1'b0;
    logic           apply_o;
    logic           apply_pend_o;
    logic [CW-1:0]  window_len_i = '0;
    logic           start_i = 1'b0;
    logic [NCH-1:0] gt_i = '0;
    logic [NCH-1:0] lt_i = '0;
    logic           done_o;
    logic [CB-1:0]  rd_chan_i = '0;
    logic [CW-1:0]  gt_cnt_o;
    logic [CW-1:0]  lt_cnt_o;

    logic           sat_clr = 1'b0;
    logic           sat_inc = 1'b0;
    logic [3:0]     sat_cnt;

    int total = 0;
    int bad   = 0;
    int seen;

    always #5 clk = ~clk;

    agc_ctrl #(.NCHAN(NCH), .CHAN_BITS(CB), .OFFSET_BITS(OB), .CNT_BITS(CW)) dut (
        .clk_i        (clk),
        .rstn_i       (rstn_i),
        .load_i       (load_i),
        .load_chan_i  (load_chan_i),
        .load_sel_i   (load_sel_i),
        .load_dat_i   (load_dat_i),
        .scale_o      (scale_o),
        .offset_o     (offset_o),
        .ce_scale_o   (ce_scale_o),
        .ce_offset_o  (ce_offset_o),
        .apply_req_i  (apply_req_i),
        .apply_o      (apply_o),
        .apply_pend_o (apply_pend_o),
        .window_len_i (window_len_i),
        .start_i      (start_i),
        .gt_i         (gt_i),
        .lt_i         (lt_i),
        .done_o       (done_o),
        .rd_chan_i    (rd_chan_i),
        .gt_cnt_o     (gt_cnt_o),
        .lt_cnt_o     (lt_cnt_o)
    );

    agc_sat_counter #(.CNT_BITS(4)) u_sat (
        .clk_i  (clk),
        .rstn_i (rstn_i),
        .clr_i  (sat_clr),
        .inc_i  (sat_inc),
        .cnt_o  (sat_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) @(negedge clk);
    endtask

    task automatic load(input logic [CB-1:0] ch, input logic sel, input logic [16:0] dat);
        load_i = 1'b1; load_chan_i = ch; load_sel_i = sel; load_dat_i = dat;
        tick();
        load_i = 1'b0;
    endtask

    task automatic read_ch(input logic [CB-1:0] ch);
        rd_chan_i = ch;
        tick();
    endtask

    initial begin
        tick(3);
        chk("rst_scale", 32'(scale_o), 32'h0);
        chk("rst_ce", {16'h0, ce_scale_o, ce_offset_o}, 32'h0);
        chk("rst_ctl", {29'h0, apply_o, apply_pend_o, done_o}, 32'h0);
        chk("rst_cnt", 32'(gt_cnt_o | lt_cnt_o), 32'h0);
        rstn_i = 1'b1;
        tick();

        // load path
        load(4'd2, 1'b0, 17'h01000);
        chk("ld_scale", 32'(scale_o), 32'h01000);
        chk("ld_ce_scale", 32'(ce_scale_o), 32'h04);
        chk("ld_ce_off0", 32'(ce_offset_o), 32'h00);
        tick();
        chk("ld_ce_pulse", 32'(ce_scale_o), 32'h00);
        chk("ld_hold", 32'(scale_o), 32'h01000);
        load(4'd5, 1'b1, 17'h1ABCD);
        chk("ld_offset", 32'(offset_o), 32'hBCD);
        chk("ld_ce_off", {16'h0, ce_scale_o, ce_offset_o}, 32'h0020);
        load(4'd9, 1'b0, 17'h00123);
        chk("ld_oor_ce", 32'(ce_scale_o), 32'h00);
        chk("ld_oor_bus", 32'(scale_o), 32'h00123);
        load(4'd15, 1'b1, 17'h00077);
`ifdef AGC_CTRL_BCAST_EN
        chk("ld_bcast", 32'(ce_offset_o), 32'hFF);
`else
        chk("ld_allones", 32'(ce_offset_o), 32'h00);
`endif
        tick();

        // apply in IDLE, request with a load in the same cycle
        apply_req_i = 1'b1;
        load(4'd1, 1'b0, 17'h00005);
        apply_req_i = 1'b0;
        chk("ap_ce", 32'(ce_scale_o), 32'h02);
        chk("ap_t1", {30'h0, apply_o, apply_pend_o}, 32'h1);
        tick();
        chk("ap_t2", {30'h0, apply_o, apply_pend_o}, 32'h2);
        apply_req_i = 1'b1;
        tick();
        apply_req_i = 1'b0;
        chk("ap_t3", {30'h0, apply_o, apply_pend_o}, 32'h1);
        tick();
        chk("ap_t4", {30'h0, apply_o, apply_pend_o}, 32'h2);
        tick();
        chk("ap_t5", {30'h0, apply_o, apply_pend_o}, 32'h0);

        // window of 100 cycles
        window_len_i = 24'd100;
        start_i = 1'b1;
        seen = 0;
        for (int i = 1; i <= 100; i++) begin
            tick();
            start_i     = (i == 70);
            gt_i[0]     = (i >= 10 && i < 40);
            lt_i[1]     = (i >= 20 && i < 25);
            apply_req_i = (i == 50 || i == 60);
            if (apply_o || done_o) seen++;
        end
        chk("win_quiet", 32'(seen), 32'd0);
        tick();
        chk("win_done", 32'(done_o), 32'h1);
        seen = 0;
        for (int j = 0; j < 4; j++) begin
            tick();
            if (apply_o) seen++;
        end
        chk("win_apply1", 32'(seen), 32'd1);
        chk("win_pend0", 32'(apply_pend_o), 32'h0);
        gt_i[0] = 1'b1;
        read_ch(4'd0);
        read_ch(4'd0);
        gt_i[0] = 1'b0;
        chk("win_gt0", 32'(gt_cnt_o), 32'd30);
        chk("win_lt0", 32'(lt_cnt_o), 32'd0);
        read_ch(4'd1);
        chk("win_lt1", 32'(lt_cnt_o), 32'd5);
        read_ch(4'd9);
        chk("rd_oor", 32'(gt_cnt_o | lt_cnt_o), 32'd0);

        // zero-length window counts one cycle
        window_len_i = 24'd0;
        start_i = 1'b1;
        gt_i[2] = 1'b1;
        tick();
        start_i = 1'b0;
        chk("w0_busy", 32'(done_o), 32'h0);
        tick();
        chk("w0_done", 32'(done_o), 32'h1);
        tick(3);
        gt_i[2] = 1'b0;
        read_ch(4'd2);
        chk("w0_gt2", 32'(gt_cnt_o), 32'd1);
        read_ch(4'd0);
        chk("w0_clr", 32'(gt_cnt_o), 32'd0);

        // three-cycle window with lt held
        window_len_i = 24'd3;
        start_i = 1'b1;
        lt_i[3] = 1'b1;
        tick();
        start_i = 1'b0;
        tick(6);
        lt_i[3] = 1'b0;
        read_ch(4'd3);
        chk("w3_lt3", 32'(lt_cnt_o), 32'd3);

        // reset mid-window with an apply pending
        window_len_i = 24'd50;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        tick(5);
        apply_req_i = 1'b1;
        load(4'd4, 1'b0, 17'h0ABCD);
        apply_req_i = 1'b0;
        rstn_i = 1'b0;
        tick();
        chk("rr_bus", {15'h0, scale_o}, 32'h0);
        chk("rr_ce", {16'h0, ce_scale_o, ce_offset_o}, 32'h0);
        chk("rr_ctl", {29'h0, apply_o, apply_pend_o, done_o}, 32'h0);
        rstn_i = 1'b1;
        seen = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (apply_o || apply_pend_o || done_o) seen++;
        end
        chk("rr_quiet", 32'(seen), 32'd0);

        // 4-bit saturating counter
        sat_clr = 1'b1;
        tick();
        sat_clr = 1'b0;
        chk("sat_clr", 32'(sat_cnt), 32'd0);
        sat_inc = 1'b1;
        tick(3);
        chk("sat_3", 32'(sat_cnt), 32'd3);
        tick(37);
        sat_inc = 1'b0;
        chk("sat_15", 32'(sat_cnt), 32'd15);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
